laa_dispatch: RTL and testbench

Issue stage in front of the LAA core-side decoder. It captures custom-0 instructions and their rs1/rs2 operands from the IF/ID stage into a small FIFO, then presents them one at a time on the LAA instruction port. A WRITE or READ is held for one cycle. A MULTIPLY is held until the LAA reports it has finished. The block stalls the core pipeline when the FIFO cannot accept a new LAA instruction.

---
 rtl/laa_pkg.sv | 34 +++
 rtl/laa_ins_fifo.sv | 62 ++++++
 rtl/laa_dispatch.sv | 134 +++++++++++++
 tb/tb_laa_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laa_pkg.sv
// Shared constants and types for the LAA issue path: custom-0 opcode,
// funct encodings and the dispatcher state type.
package laa_pkg;

    localparam logic [6:0] LAA_CUSTOM0 = 7'b0001011;

    localparam logic [4:0] LAA_F_WRITE = 5'b00010;
    localparam logic [4:0] LAA_F_READ  = 5'b00001;
    localparam logic [4:0] LAA_F_MUL   = 5'b00011;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXEC
    } laa_disp_state_t;

    typedef enum logic [4:0] {
        LAA_WRITE = 5'b00010,
        LAA_READ  = 5'b00001,
        LAA_MUL   = 5'b00011
    } LAA_opcode;

    // Only these three functs are understood by the LAA decoder.
    function automatic logic laa_funct_legal(input logic [4:0] funct);
        logic ok;
        ok = 1'b0;
        case (funct)
            LAA_F_WRITE, LAA_F_READ, LAA_F_MUL: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/laa_ins_fifo.sv
// Synchronous instruction/operand FIFO. Full and empty come from the
// registered occupancy so the stall path never compares pointers.
module laa_ins_fifo
    import laa_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/laa_dispatch.sv
// LAA issue stage: classifies custom-0 instructions from IF/ID, queues them
// with their operands and presents them one at a time to the LAA decoder.
module laa_dispatch
    import laa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic                       ins_valid,
    input  logic [31:0]                ins,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    output logic                       laa_stall,
    output logic [31:0]                laa_ins,
    output logic [XLEN-1:0]            laa_rs1,
    output logic [XLEN-1:0]            laa_rs2,
    input  logic                       laa_busy,
    output logic                       laa_pending,
    output logic                       err_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int W = 32 + 2 * XLEN;

    laa_disp_state_t state;
    laa_disp_state_t state_next;

    logic         is_laa;
    logic         legal;
    logic         push;
    logic         pop;
    logic         load;
    logic         clear;
    logic         full;
    logic         empty;
    logic [W-1:0] head;
    logic [1:0]   exec_cnt;
    logic         exec_done;

    assign is_laa      = ins_valid & (ins[6:0] == LAA_CUSTOM0);
    assign legal       = laa_funct_legal(ins[11:7]);
    assign laa_stall   = is_laa & legal & full;
    assign push        = is_laa & legal & ~full;
    assign laa_pending = (count != '0) | (state != IDLE);

    laa_ins_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (push),
        .din   ({ins, rs1_data, rs2_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The head stays in the FIFO while it is presented; it is popped only
    // when its hold ends, and every hold returns through IDLE for one gap cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (laa_ins[11:7] == LAA_F_MUL) begin
                    state_next = EXEC;
                end else begin
                    pop        = 1'b1;
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    pop        = 1'b1;
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts EXEC cycles so a MULTIPLY shows funct 11 for at least two of them.
    always_ff @(posedge clk) begin
        if (Rst || state != EXEC) begin
            exec_cnt <= '0;
        end else if (exec_cnt != 2'd3) begin
            exec_cnt <= exec_cnt + 2'd1;
        end
    end

    assign exec_done = (exec_cnt != '0) & ~laa_busy;

    always_ff @(posedge clk) begin
        if (Rst) begin
            laa_ins     <= '0;
            laa_rs1     <= '0;
            laa_rs2     <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= is_laa & ~legal;
            if (load) begin
                {laa_ins, laa_rs1, laa_rs2} <= head;
            end else if (clear) begin
                laa_ins <= '0;
                laa_rs1 <= '0;
                laa_rs2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_laa_dispatch.sv
// Self-checking bench for laa_dispatch: a queue-based model of the issue
// timeline is compared every cycle, plus directed literal expectations.
module tb_laa_dispatch;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            Rst;
    logic            ins_valid;
    logic [31:0]     ins;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            laa_stall;
    logic [31:0]     laa_ins;
    logic [XLEN-1:0] laa_rs1;
    logic [XLEN-1:0] laa_rs2;
    logic            laa_busy;
    logic            laa_pending;
    logic            err_illegal;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    laa_dispatch #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk         (clk),
        .Rst         (Rst),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .laa_stall   (laa_stall),
        .laa_ins     (laa_ins),
        .laa_rs1     (laa_rs1),
        .laa_rs2     (laa_rs2),
        .laa_busy    (laa_busy),
        .laa_pending (laa_pending),
        .err_illegal (err_illegal),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of accepted entries plus the entry being presented.
    typedef struct packed {
        logic [31:0]     ins;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    entry_t mq[$];
    entry_t cur;
    bit     cur_valid  = 0;
    int     cur_age    = 0;
    bit     exp_err    = 0;
    bit     model_live = 0;
    int     size_before;
    bit     can_push;
    bit     hold_over;

    logic [31:0] issued_log[$];
    logic [31:0] prev_ins = 32'h0;

    function automatic bit isCustom(input logic v, input logic [31:0] w);
        return v && (w[6:0] == 7'h0B);
    endfunction

    function automatic bit isLegalLaa(input logic v, input logic [31:0] w);
        return isCustom(v, w) && (w[11:7] == 5'd1 || w[11:7] == 5'd2 || w[11:7] == 5'd3);
    endfunction

    always @(posedge clk) begin
        if (Rst) begin
            mq.delete();
            cur_valid  = 0;
            cur_age    = 0;
            exp_err    = 0;
            model_live = 1;
        end else if (model_live) begin
            size_before = mq.size();
            can_push    = isLegalLaa(ins_valid, ins) && (size_before < DEPTH);
            exp_err     = isCustom(ins_valid, ins) && !isLegalLaa(ins_valid, ins);
            if (cur_valid) begin
                cur_age++;
                if (cur.ins[11:7] == 5'd3)
                    hold_over = (cur_age >= 3) && !laa_busy;
                else
                    hold_over = (cur_age >= 1);
                if (hold_over) begin
                    void'(mq.pop_front());
                    cur_valid = 0;
                end
            end else if (size_before != 0) begin
                cur       = mq[0];
                cur_valid = 1;
                cur_age   = 0;
            end
            if (can_push)
                mq.push_back(entry_t'({ins, rs1_data, rs2_data}));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("cmp_ins", laa_ins, cur_valid ? cur.ins : 32'h0);
            checkOutput("cmp_rs1", laa_rs1, cur_valid ? cur.rs1 : 32'h0);
            checkOutput("cmp_rs2", laa_rs2, cur_valid ? cur.rs2 : 32'h0);
            checkOutput("cmp_count", 32'(count), 32'(mq.size()));
            checkOutput("cmp_pending", 32'(laa_pending), 32'((mq.size() != 0) || cur_valid));
            checkOutput("cmp_err", 32'(err_illegal), 32'(exp_err));
            checkOutput("cmp_stall", 32'(laa_stall),
                        32'(isLegalLaa(ins_valid, ins) && (mq.size() == DEPTH)));
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            if (laa_ins !== 32'h0 && prev_ins === 32'h0)
                issued_log.push_back(laa_ins);
            prev_ins = laa_ins;
        end
    end

    // Presents one instruction, keeps it on IF/ID while stalled, returns just after acceptance.
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                                 output bit sawStall);
        bit s;
        int tries;
        sawStall  = 0;
        tries     = 0;
        ins_valid = 1'b1;
        ins       = w;
        rs1_data  = a;
        rs2_data  = b;
        do begin
            @(negedge clk);
            s = laa_stall;
            if (s) sawStall = 1;
            @(posedge clk);
            #1;
            tries++;
        end while (s && tries < 50);
        checkOutput("accept_bound", 32'(s), 32'h0);
        ins_valid = 1'b0;
        ins       = 32'h0;
        rs1_data  = '0;
        rs2_data  = '0;
    endtask

    task automatic measureHold(input logic [31:0] w, input int busyCycles, output int hold);
        int waits;
        hold  = 0;
        waits = 0;
        @(negedge clk);
        while (laa_ins !== w && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        while (laa_ins === w && hold < 40) begin
            hold++;
            if (busyCycles > 0 && hold == busyCycles + 1) laa_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [31:0] fill_words [5];
    bit          st;
    int          hold;

    initial begin
        fill_words[0] = 32'h1000018B;
        fill_words[1] = 32'h2000018B;
        fill_words[2] = 32'h3000018B;
        fill_words[3] = 32'h4000018B;
        fill_words[4] = 32'h5000018B;
        ins_valid = 1'b0;
        ins       = 32'h0;
        rs1_data  = '0;
        rs2_data  = '0;
        laa_busy  = 1'b0;
        Rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 Rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_ins", laa_ins, 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_pending", 32'(laa_pending), 32'h0);
        checkOutput("reset_err", 32'(err_illegal), 32'h0);

        $display("[TB] WRITE latency");
        @(posedge clk); #1;
        applyStimulus(32'h0880010B, 32'hDEADBEEF, 32'h12345678, st);
        @(negedge clk);
        checkOutput("wr_gap_ins", laa_ins, 32'h0);
        @(negedge clk);
        checkOutput("wr_ins", laa_ins, 32'h0880010B);
        checkOutput("wr_rs1", laa_rs1, 32'hDEADBEEF);
        checkOutput("wr_rs2", laa_rs2, 32'h12345678);
        @(negedge clk);
        checkOutput("wr_after_ins", laa_ins, 32'h0);
        checkOutput("wr_after_count", 32'(count), 32'h0);

        $display("[TB] READ operands");
        @(posedge clk); #1;
        applyStimulus(32'h0000008B, 32'h00000011, 32'hCAFEF00D, st);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rd_ins", laa_ins, 32'h0000008B);
        checkOutput("rd_rs2", laa_rs2, 32'hCAFEF00D);

        $display("[TB] MULTIPLY hold");
        @(posedge clk); #1;
        applyStimulus(32'h0000018B, 32'h3, 32'h5, st);
        measureHold(32'h0000018B, 0, hold);
        checkOutput("mul_hold_free", 32'(hold), 32'd3);
        @(posedge clk); #1;
        laa_busy = 1'b1;
        applyStimulus(32'h0100018B, 32'h7, 32'h9, st);
        measureHold(32'h0100018B, 6, hold);
        checkOutput("mul_hold_busy", 32'(hold), 32'd7);

        $display("[TB] Fill and stall");
        @(posedge clk); #1;
        issued_log.delete();
        laa_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(fill_words[k], 32'(k), 32'(k + 100), st);
            checkOutput("fill_no_stall", 32'(st), 32'h0);
        end
        fork
            begin
                applyStimulus(fill_words[4], 32'd4, 32'd104, st);
            end
            begin
                repeat (6) @(posedge clk);
                #1 laa_busy = 1'b0;
            end
        join
        checkOutput("fill_fifth_stall", 32'(st), 32'h1);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("fill_issued_n", 32'(issued_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            checkOutput("fill_order", (k < issued_log.size()) ? issued_log[k] : 32'h0, fill_words[k]);
        checkOutput("fill_drained", 32'(count), 32'h0);

        $display("[TB] Illegal and foreign opcodes");
        applyStimulus(32'h0000028B, 32'h1, 32'h2, st);
        @(negedge clk);
        checkOutput("ill_err_pulse", 32'(err_illegal), 32'h1);
        checkOutput("ill_count", 32'(count), 32'h0);
        @(negedge clk);
        checkOutput("ill_err_end", 32'(err_illegal), 32'h0);
        @(posedge clk); #1;
        applyStimulus(32'h00000033, 32'h1, 32'h2, st);
        @(negedge clk);
        checkOutput("foreign_err", 32'(err_illegal), 32'h0);
        checkOutput("foreign_count", 32'(count), 32'h0);

        $display("[TB] Reset during EXEC");
        @(posedge clk); #1;
        laa_busy = 1'b1;
        applyStimulus(32'h0A00018B, 32'hA, 32'hA, st);
        applyStimulus(32'h0B00008B, 32'hB, 32'hB, st);
        applyStimulus(32'h0C00018B, 32'hC, 32'hC, st);
        @(negedge clk);
        checkOutput("rst_pre_ins", laa_ins, 32'h0A00018B);
        checkOutput("rst_pre_count", 32'(count), 32'd3);
        @(posedge clk); #1;
        Rst = 1'b1;
        @(posedge clk); #1;
        Rst      = 1'b0;
        laa_busy = 1'b0;
        @(negedge clk);
        checkOutput("rst_ins", laa_ins, 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_pending", 32'(laa_pending), 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("rst_stays_idle", laa_ins, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
